mem_wb_load_stage: RTL and testbench

//  MEM/WB pipeline stage feeding the writeback result mux.
//  - Takes EX/MEM fields and runs load handshakes with data memory.
//  - Byte-aligns and sign/zero-extends load data.
//  - Registers ALUResult, ReadData, OP1 and Rd control for the WB stage.
//  - Stalls upstream while a load is outstanding.

---
 rtl/mem_wb_load_stage.sv | 236 +++++++++++++++++++++++
 tb/tb_mem_wb_load_stage.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_load_stage.sv
// MEM/WB stage: load handshake, byte/half extraction and WB registers.
// Optional LOAD_TIMEOUT_EN bounds the WAIT state and reports load_err.
module mem_wb_load_stage
`ifdef LOAD_TIMEOUT_EN
#(
   parameter int unsigned TIMEOUT_CYCLES = 16
)
`endif
(
   input  logic        clk,
   input  logic        Reset,
   input  logic        ex_valid,
   input  logic [31:0] ex_alu,
   input  logic [4:0]  ex_rd,
   input  logic        ex_regwrite,
   input  logic        ex_memread,
   input  logic [1:0]  ex_op1,
   input  logic [2:0]  ex_funct3,
   input  logic        flush,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        stall,
   output logic        wb_valid,
   output logic [31:0] ALUResult,
   output logic [31:0] ReadData,
   output logic [1:0]  OP1,
   output logic [4:0]  wb_rd,
   output logic        wb_regwrite,
   output logic        misalign,
   output logic        load_err
);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t      state_q, state_d;
   logic        cancel_q, cancel_d;
   logic [31:0] addr_q, addr_d;
   logic [2:0]  f3_q, f3_d;
   logic [4:0]  lrd_q, lrd_d;
   logic        lrw_q, lrw_d;
   logic [1:0]  lop_q, lop_d;

   logic        wb_valid_q, wb_valid_d;
   logic [31:0] alu_q, alu_d;
   logic [31:0] rdata_q, rdata_d;
   logic [1:0]  op1_q, op1_d;
   logic [4:0]  rd_q, rd_d;
   logic        rw_q, rw_d;
   logic        mis_q, mis_d;
   logic        ex_mis;
   logic        kill;

`ifdef LOAD_TIMEOUT_EN
   localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;
`endif

   function automatic logic [31:0] load_ext(
      input logic [31:0] w,
      input logic [1:0]  a,
      input logic [2:0]  f3
   );
      logic [7:0]  b;
      logic [15:0] h;
      case (a)
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         default: b = w[31:24];
      endcase
      h = a[1] ? w[31:16] : w[15:0];
      case (f3)
         3'b000:  load_ext = {{24{b[7]}}, b};
         3'b001:  load_ext = {{16{h[15]}}, h};
         3'b100:  load_ext = {24'd0, b};
         3'b101:  load_ext = {16'd0, h};
         default: load_ext = w;
      endcase
   endfunction

   always_comb begin
      case (ex_funct3)
         3'b000, 3'b100: ex_mis = 1'b0;
         3'b001, 3'b101: ex_mis = ex_alu[0];
         default:        ex_mis = |ex_alu[1:0];
      endcase
   end

   always_comb begin
      state_d    = state_q;
      cancel_d   = cancel_q;
      addr_d     = addr_q;
      f3_d       = f3_q;
      lrd_d      = lrd_q;
      lrw_d      = lrw_q;
      lop_d      = lop_q;
      wb_valid_d = 1'b0;
      alu_d      = alu_q;
      rdata_d    = rdata_q;
      op1_d      = op1_q;
      rd_d       = rd_q;
      rw_d       = 1'b0;
      mis_d      = 1'b0;
      mem_req    = 1'b0;
      stall      = 1'b0;
      mem_addr   = {ex_alu[31:2], 2'b00};
      kill       = cancel_q | flush;
`ifdef LOAD_TIMEOUT_EN
      cnt_d      = '0;
      err_d      = 1'b0;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (ex_valid && !flush) begin
               if (ex_memread && !ex_mis) begin
                  mem_req  = 1'b1;
                  stall    = 1'b1;
                  state_d  = S_WAIT;
                  cancel_d = 1'b0;
                  addr_d   = ex_alu;
                  f3_d     = ex_funct3;
                  lrd_d    = ex_rd;
                  lrw_d    = ex_regwrite;
                  lop_d    = ex_op1;
               end else begin
                  wb_valid_d = 1'b1;
                  alu_d      = ex_alu;
                  rdata_d    = 32'd0;
                  op1_d      = ex_op1;
                  rd_d       = ex_rd;
                  rw_d       = ex_regwrite & ~ex_memread;
                  mis_d      = ex_memread;
               end
            end
         end
         S_WAIT: begin
            mem_req  = 1'b1;
            mem_addr = {addr_q[31:2], 2'b00};
            cancel_d = kill;
            if (mem_ack) begin
               state_d    = S_IDLE;
               cancel_d   = 1'b0;
               wb_valid_d = ~kill;
               alu_d      = addr_q;
               rdata_d    = load_ext(mem_rdata, addr_q[1:0], f3_q);
               op1_d      = lop_q;
               rd_d       = lrd_q;
               rw_d       = lrw_q & ~kill;
            end else begin
               stall = 1'b1;
`ifdef LOAD_TIMEOUT_EN
               // Stall drops on the give-up cycle so the load is not reissued.
               if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                  stall      = 1'b0;
                  state_d    = S_IDLE;
                  cancel_d   = 1'b0;
                  wb_valid_d = 1'b1;
                  alu_d      = addr_q;
                  rdata_d    = 32'hDEADBEEF;
                  op1_d      = lop_q;
                  rd_d       = lrd_q;
                  err_d      = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
`endif
            end
         end
      endcase
      if (Reset) begin
         mem_req = 1'b0;
         stall   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         state_q    <= S_IDLE;
         cancel_q   <= 1'b0;
         addr_q     <= '0;
         f3_q       <= '0;
         lrd_q      <= '0;
         lrw_q      <= 1'b0;
         lop_q      <= '0;
         wb_valid_q <= 1'b0;
         alu_q      <= '0;
         rdata_q    <= '0;
         op1_q      <= '0;
         rd_q       <= '0;
         rw_q       <= 1'b0;
         mis_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cancel_q   <= cancel_d;
         addr_q     <= addr_d;
         f3_q       <= f3_d;
         lrd_q      <= lrd_d;
         lrw_q      <= lrw_d;
         lop_q      <= lop_d;
         wb_valid_q <= wb_valid_d;
         alu_q      <= alu_d;
         rdata_q    <= rdata_d;
         op1_q      <= op1_d;
         rd_q       <= rd_d;
         rw_q       <= rw_d;
         mis_q      <= mis_d;
      end
   end

`ifdef LOAD_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (Reset) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end
   assign load_err = err_q;
`else
   assign load_err = 1'b0;
`endif

   assign wb_valid    = wb_valid_q;
   assign ALUResult   = alu_q;
   assign ReadData    = rdata_q;
   assign OP1         = op1_q;
   assign wb_rd       = rd_q;
   assign wb_regwrite = rw_q;
   assign misalign    = mis_q;

endmodule

// File: tb/tb_mem_wb_load_stage.sv
// Scoreboard bench for mem_wb_load_stage (default build).
// Expected WB records are queued at issue and popped on wb_valid.
module tb_mem_wb_load_stage;

   logic        clk = 1'b0;
   logic        Reset;
   logic        ex_valid;
   logic [31:0] ex_alu;
   logic [4:0]  ex_rd;
   logic        ex_regwrite;
   logic        ex_memread;
   logic [1:0]  ex_op1;
   logic [2:0]  ex_funct3;
   logic        flush;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        stall;
   logic        wb_valid;
   logic [31:0] ALUResult;
   logic [31:0] ReadData;
   logic [1:0]  OP1;
   logic [4:0]  wb_rd;
   logic        wb_regwrite;
   logic        misalign;
   logic        load_err;

   always #5 clk = ~clk;

   mem_wb_load_stage dut (
      .clk(clk), .Reset(Reset), .ex_valid(ex_valid), .ex_alu(ex_alu),
      .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
      .ex_op1(ex_op1), .ex_funct3(ex_funct3), .flush(flush),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata), .stall(stall), .wb_valid(wb_valid),
      .ALUResult(ALUResult), .ReadData(ReadData), .OP1(OP1),
      .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .misalign(misalign),
      .load_err(load_err)
   );

   typedef struct {
      logic [31:0] alu;
      logic [31:0] rdata;
      logic [1:0]  op1;
      logic [4:0]  rd;
      logic        rw;
      logic        mis;
   } exp_t;

   exp_t sb[$];
   exp_t pe;
   int   n_chk = 0;
   int   n_err = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ext_model(input logic [31:0] w,
                                             input logic [1:0] a,
                                             input logic [2:0] f3);
      logic [31:0] bs, hs;
      bs = w >> (8 * a);
      hs = w >> (16 * a[1]);
      if (f3 == 3'b000) return 32'($signed(bs[7:0]));
      if (f3 == 3'b100) return {24'd0, bs[7:0]};
      if (f3 == 3'b001) return 32'($signed(hs[15:0]));
      if (f3 == 3'b101) return {16'd0, hs[15:0]};
      return w;
   endfunction

   always @(negedge clk) begin
      if (!Reset) begin
         if (wb_valid) begin
            if (sb.size() == 0) begin
               check("unexp_wb", 32'd1, 32'd0);
            end else begin
               pe = sb.pop_front();
               check("wb_alu", ALUResult, pe.alu);
               check("wb_rdata", ReadData, pe.rdata);
               check("wb_op1", 32'(OP1), 32'(pe.op1));
               check("wb_rd", 32'(wb_rd), 32'(pe.rd));
               check("wb_rw", 32'(wb_regwrite), 32'(pe.rw));
               check("wb_mis", 32'(misalign), 32'(pe.mis));
            end
         end else begin
            check("nv_rw", 32'(wb_regwrite), 32'd0);
            check("nv_mis", 32'(misalign), 32'd0);
         end
         check("ld_err", 32'(load_err), 32'd0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      ex_valid   = 1'b0;
      ex_memread = 1'b0;
      flush      = 1'b0;
      mem_ack    = 1'b0;
      mem_rdata  = $urandom;
   endtask

   task automatic drive_ex(input logic [31:0] a, input logic [2:0] f3,
                           input logic mr, input logic [1:0] op,
                           input logic [4:0] rd, input logic rw);
      ex_valid    = 1'b1;
      ex_alu      = a;
      ex_funct3   = f3;
      ex_memread  = mr;
      ex_op1      = op;
      ex_rd       = rd;
      ex_regwrite = rw;
   endtask

   task automatic alu_op(input logic [31:0] a, input logic [1:0] op,
                         input logic [4:0] rd, input logic rw);
      drive_ex(a, 3'b000, 1'b0, op, rd, rw);
      sb.push_back('{a, 32'd0, op, rd, rw, 1'b0});
      #1;
      check("alu_stall", 32'(stall), 32'd0);
      check("alu_req", 32'(mem_req), 32'd0);
      tick();
      idle_in();
   endtask

   task automatic do_load(input logic [31:0] a, input logic [2:0] f3,
                          input logic [31:0] word, input logic [31:0] expd,
                          input int dly, input logic fl);
      drive_ex(a, f3, 1'b1, 2'd1, 5'd7, 1'b1);
      if (!fl) sb.push_back('{a, expd, 2'd1, 5'd7, 1'b1, 1'b0});
      #1;
      check("ld_req0", 32'(mem_req), 32'd1);
      check("ld_stall0", 32'(stall), 32'd1);
      check("ld_addr0", mem_addr, {a[31:2], 2'b00});
      for (int k = 1; k <= dly; k++) begin
         tick();
         flush = fl && (k == 1);
         if (k == dly) begin
            mem_ack   = 1'b1;
            mem_rdata = word;
         end
         #1;
         check("ld_req", 32'(mem_req), 32'd1);
         check("ld_addr", mem_addr, {a[31:2], 2'b00});
         check("ld_stall", 32'(stall), (k == dly) ? 32'd0 : 32'd1);
      end
      tick();
      idle_in();
   endtask

   task automatic mis_load(input logic [31:0] a, input logic [2:0] f3);
      drive_ex(a, f3, 1'b1, 2'd1, 5'd9, 1'b1);
      sb.push_back('{a, 32'd0, 2'd1, 5'd9, 1'b0, 1'b1});
      #1;
      check("mis_req", 32'(mem_req), 32'd0);
      check("mis_stall", 32'(stall), 32'd0);
      tick();
      idle_in();
      #1;
      check("mis_req1", 32'(mem_req), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      logic [2:0]  f3s[6];
      logic [31:0] w, a;
      f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011};
      Reset = 1'b1;
      ex_alu = '0; ex_rd = '0; ex_regwrite = 1'b0;
      ex_op1 = '0; ex_funct3 = '0;
      idle_in();
      tick();
      tick();
      check("rst_valid", 32'(wb_valid), 32'd0);
      check("rst_alu", ALUResult, 32'd0);
      check("rst_rdata", ReadData, 32'd0);
      check("rst_req", 32'(mem_req), 32'd0);
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_rw", 32'(wb_regwrite), 32'd0);
      Reset = 1'b0;
      tick();

      alu_op(32'h1234, 2'd3, 5'd5, 1'b1);
      tick();
      check("hold_valid", 32'(wb_valid), 32'd0);
      check("hold_alu", ALUResult, 32'h1234);
      check("hold_op1", 32'(OP1), 32'd3);
      check("hold_rd", 32'(wb_rd), 32'd5);

      do_load(32'h103, 3'b000, 32'h80FF0011, 32'hFFFFFF80, 3, 1'b0);
      do_load(32'h103, 3'b100, 32'h80FF0011, 32'h00000080, 3, 1'b0);
      mis_load(32'h101, 3'b001);
      mis_load(32'h102, 3'b010);
      do_load(32'h102, 3'b101, 32'hBEEF0000, 32'h0000BEEF, 1, 1'b0);
      do_load(32'h100, 3'b001, 32'h1234F00D, 32'hFFFFF00D, 2, 1'b0);

      drive_ex(32'h55, 3'b000, 1'b0, 2'd2, 5'd3, 1'b1);
      flush = 1'b1;
      tick();
      idle_in();
      #1;
      check("flush_idle", 32'(wb_valid), 32'd0);

      do_load(32'h300, 3'b010, 32'hCAFEF00D, 32'd0, 3, 1'b1);
      tick();
      check("flush_wait", 32'(wb_valid), 32'd0);

      drive_ex(32'h200, 3'b010, 1'b1, 2'd1, 5'd4, 1'b1);
      #1;
      check("rw_req", 32'(mem_req), 32'd1);
      tick();
      Reset = 1'b1;
      #1;
      check("rw_req_rst", 32'(mem_req), 32'd0);
      tick();
      Reset = 1'b0;
      ex_valid  = 1'b0;
      mem_ack   = 1'b1;
      mem_rdata = 32'h12345678;
      #1;
      check("rw_req_ack", 32'(mem_req), 32'd0);
      check("rw_stall", 32'(stall), 32'd0);
      check("rw_alu", ALUResult, 32'd0);
      check("rw_rdata", ReadData, 32'd0);
      check("rw_op1", 32'(OP1), 32'd0);
      check("rw_wbrd", 32'(wb_rd), 32'd0);
      tick();
      mem_ack = 1'b0;
      #1;
      check("rw_late", 32'(wb_valid), 32'd0);
      alu_op(32'hA5A5_0001, 2'd0, 5'd31, 1'b0);

      for (int i = 0; i < 24; i++) begin
         a = 32'h4000 + 32'($urandom_range(0, 255)) * 4;
         w = $urandom;
         case (f3s[i % 6])
            3'b000, 3'b100: a[1:0] = 2'(i);
            3'b001, 3'b101: a[1] = 1'(i);
            default: ;
         endcase
         do_load(a, f3s[i % 6], w, ext_model(w, a[1:0], f3s[i % 6]),
                 $urandom_range(1, 4), 1'b0);
         if (i % 5 == 0) alu_op($urandom, 2'(i), 5'(i), 1'b1);
      end

      tick();
      tick();
      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
